uart_rx_ctrl: RTL
=================

Name: uart_rx_ctrl

Overview:
UART receive sequencer driven by the 16x-oversampling baud tick that the baud timer produces (its `done` pulse).
- Synchronises the asynchronous `rx` line, detects and validates the start bit, and samples each data bit at mid-bit.
- Checks the stop bit, then presents the assembled byte with a one-cycle done strobe.
- Sits between the baud timer and the receive FIFO / user logic.

Parameters:
- DBIT, 8, number of data bits per frame (5..9), LSB first.
- SB_TICK, 16, oversample ticks spanning the stop bit(s): 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, asynchronous, idle high
- s_tick  input  1  one-clk pulse at 16x baud rate, from the baud timer
- rx_dout  output  DBIT  received data word, held until next frame completes
- rx_done_tick  output  1  one-clk pulse when a frame completes
- frame_err  output  1  stop-bit error flag for the frame just completed
- busy  output  1  high in any state other than IDLE

Behaviour:
Reset and synchroniser:
- One clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- Reset values: state=IDLE, s=0, n=0, shift reg=0, rx_dout=0, rx_done_tick=0, frame_err=0, busy=0, synchroniser flops=1.
- `rx` passes through a 2-flop synchroniser (rx_s); input-to-FSM latency is 2 clk.

Counters:
- s: oversample counter, width = max(4, clog2(SB_TICK)).
- n: bit counter, width clog2(DBIT).
- b: shift register, DBIT bits.
- Counters advance only on cycles where s_tick=1; the FSM holds state otherwise.

States:
- IDLE: when rx_s==0, go to START with s=0. s_tick is ignored in IDLE.
- START: on s_tick, if s==7 (mid start bit):
  - rx_s==0 → DATA, s=0, n=0.
  - rx_s==1 → IDLE (glitch reject, no output activity).
  - Otherwise s++.
- DATA: on s_tick, if s==15 → s=0, b={rx_s, b[DBIT-1:1]}, then:
  - n==DBIT-1 → STOP.
  - Otherwise n++.
  - Otherwise s++.
- STOP: on s_tick, if s==SB_TICK-1 → in the same registered update, rx_dout=b, frame_err=~rx_s, rx_done_tick=1 for exactly one clk, then go to IDLE. Otherwise s++.

Outputs and boundary conditions:
- rx_dout and frame_err hold their values until the next completed frame. frame_err is never cleared by a glitch reject.
- Back-to-back frames: a start edge seen in the clk after STOP→IDLE is accepted; no idle gap is required beyond the stop bit.
- Line held low (break): the frame completes with frame_err=1 and rx_dout=0. The FSM then re-enters START immediately and repeats for as long as the line stays low.
- s_tick asserted every clk is legal; behaviour is identical, just time-compressed.
- Reset mid-frame: returns to IDLE immediately and no done pulse is generated. A partially received word never reaches rx_dout.

Decomposition:
- Shared package/include uart_defs: state encodings (IDLE=0, START=1, DATA=2, STOP=3) and OVERSAMPLE=16 with derived MID_SAMPLE=7. The baud timer configuration uses the same OVERSAMPLE.
- One natural sub-module: sync_2ff (2-flop synchroniser with parameterised reset value, here 1), reused for other asynchronous inputs.

Test Plan:
Common bench setup: clk 10 ns, s_tick one pulse every 4 clk (baud = clk/64), frames driven at 64 clk per bit.
1. Frame 0x55, 1 stop bit → exactly one rx_done_tick; rx_dout=0x55, frame_err=0, busy falls the clk after done.
2. Frame 0x01 then 0x80 back-to-back, no idle gap → two done pulses; rx_dout=0x01 then 0x80 (confirms LSB-first).
3. rx low for 3 ticks then high (glitch) → FSM returns to IDLE at s==7, no done pulse; rx_dout and frame_err unchanged from the previous frame.
4. Frame 0xA3 with stop bit forced 0 → done pulse, rx_dout=0xA3, frame_err=1. The following good frame 0x3C clears frame_err to 0.
5. reset_n pulsed low in the middle of data bit 4 → all outputs reach reset values asynchronously, no done pulse. The next frame 0xC6 is received correctly.
6. SB_TICK=32, DBIT=7, frame 0x5A → done occurs 32 ticks after the last data-bit sample; rx_dout=0x5A.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART receive definitions: FSM state encodings, oversampling
// constants and a helper that sizes the oversample counter.
package uart_rx_ctrl_pkg;

  // FSM state encodings (kept as plain constants so legacy code can reuse them)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Oversampling ratio shared with the baud timer configuration
  localparam int OVERSAMPLE = 16;
  // Tick index that lands in the middle of a bit (counted from the falling edge)
  localparam int MID_SAMPLE = OVERSAMPLE / 2 - 1;

  // Oversample counter must reach both OVERSAMPLE-1 and SB_TICK-1
  function automatic int s_width(input int sb_tick);
    return ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
  endfunction

endpackage : uart_rx_ctrl_pkg

// File: rtl/uart_rx_ctrl_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset
// value so that idle-high lines do not look active while reset is released.
module uart_rx_ctrl_sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_rx_ctrl_sync_2ff

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer. Runs off the 16x oversampling tick from the baud
// timer: validates the start bit at mid-bit, samples each data bit (LSB
// first) at mid-bit, checks the stop bit and publishes the word with a
// single-cycle done strobe.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DBIT    = 8,   // data bits per frame, 5..9
  parameter int SB_TICK = 16   // oversample ticks spanning the stop bit(s)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int SW = s_width(SB_TICK);
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            busy_q;

  // The serial line idles high, so the synchroniser resets to 1
  uart_rx_ctrl_sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  // Next-state logic: counters only move on oversample ticks
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Start-edge detection is immediate; s_tick is not needed here
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high before mid start bit: treat as noise
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, counters, shift register and published outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Busy tracks the registered state one clk late so it still covers the done strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_q != ST_IDLE);
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign busy         = busy_q;

endmodule : uart_rx_ctrl
